// File: rtl/router_stat_pkg.sv
// Shared types for the router stat profiler, serializer and trace sinks.
//   router_stat_rec_s   : one streamed record (default widths: 32-bit counters, 5 directions)
//   router_dir_e        : mesh-router output direction order
//   router_stat_state_e : serializer FSM states
package router_stat_pkg;

   localparam int unsigned gctr_width_lp = 32;
   localparam int unsigned stat_width_lp = 32;
   localparam int unsigned dir_width_lp  = 3;

   typedef enum logic [dir_width_lp-1:0] {
      DirP = 3'd0,
      DirW = 3'd1,
      DirE = 3'd2,
      DirN = 3'd3,
      DirS = 3'd4
   } router_dir_e;

   typedef enum logic [0:0] {
      StIdle,
      StSend
   } router_stat_state_e;

   typedef struct packed {
      logic [gctr_width_lp-1:0] global_ctr;
      logic [dir_width_lp-1:0]  dir;
      logic [stat_width_lp-1:0] idle;
      logic [stat_width_lp-1:0] utilized;
      logic [stat_width_lp-1:0] stalled;
      logic [stat_width_lp-1:0] arbitrated;
   } router_stat_rec_s;

endpackage

// File: rtl/router_stat_snapshot.sv
// Snapshot register bank: current and previous copies of all four stat counters for every
// direction, plus one modulo-2^ctr_width_p subtractor per field and direction.
//   clk_i, reset_n_i : clock, synchronous active-low reset (clears both banks)
//   load_i           : capture live counters into cur, shift old cur into prev
//   idle_i .. arbitrated_i : live counters, direction d at bits [d*ctr_width_p +: ctr_width_p]
//   delta_o          : cur - prev, field f / direction d at [(f*dirs_p + d)*ctr_width_p +: ctr]
//                      with field order idle=0, utilized=1, stalled=2, arbitrated=3
module router_stat_snapshot #(
   parameter int unsigned dirs_p      = 5,
   parameter int unsigned ctr_width_p = 32,
   parameter int unsigned delta_p     = 1
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic                            load_i,
   input  logic [dirs_p*ctr_width_p-1:0]   idle_i,
   input  logic [dirs_p*ctr_width_p-1:0]   utilized_i,
   input  logic [dirs_p*ctr_width_p-1:0]   stalled_i,
   input  logic [dirs_p*ctr_width_p-1:0]   arbitrated_i,
   output logic [4*dirs_p*ctr_width_p-1:0] delta_o
);

   logic [3:0][dirs_p-1:0][ctr_width_p-1:0] live;
   logic [3:0][dirs_p-1:0][ctr_width_p-1:0] cur_q;
   logic [3:0][dirs_p-1:0][ctr_width_p-1:0] prev_q;
   logic [3:0][dirs_p-1:0][ctr_width_p-1:0] delta;

   assign live = {arbitrated_i, stalled_i, utilized_i, idle_i};

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         cur_q  <= '0;
         prev_q <= '0;
      end else if (load_i) begin
         cur_q  <= live;
         // Absolute mode: prev stays zero so the subtractors pass cur straight through.
         prev_q <= (delta_p != 0) ? cur_q : '0;
      end
   end

   // Plain unsigned subtraction wraps, so a counter rollover still yields the true delta.
   always_comb begin
      delta = '0;
      for (int f = 0; f < 4; f++) begin
         for (int d = 0; d < int'(dirs_p); d++) begin
            delta[f][d] = cur_q[f][d] - prev_q[f][d];
         end
      end
   end

   assign delta_o = delta;

endmodule

// File: rtl/router_stat_serializer.sv
// Streams one stat record per output direction after each dump strobe.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   snap_v_i         : one-cycle dump strobe; ignored (and counted) while a dump is streaming
//   global_ctr_i     : global cycle counter, latched with the snapshot
//   idle_i .. arbitrated_i : live counters, direction d at bits [d*ctr_width_p +: ctr_width_p]
//   v_o, data_o, ready_i   : record stream {global_ctr, dir, idle, utilized, stalled, arbitrated}
//                            (matches router_stat_rec_s for default parameters)
//   busy_o           : high while a snapshot is being streamed
//   drop_count_o     : saturating count of dropped strobes
module router_stat_serializer
   import router_stat_pkg::*;
#(
   parameter int unsigned dims_p       = 2,
   parameter int unsigned ctr_width_p  = 32,
   parameter int unsigned delta_p      = 1,
   parameter int unsigned drop_width_p = 16,
   localparam int unsigned dirs_lp      = 1 + 2 * dims_p,
   localparam int unsigned dir_width_lp = $clog2(dirs_lp),
   localparam int unsigned rec_width_lp = gctr_width_lp + dir_width_lp + 4 * ctr_width_p
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           snap_v_i,
   input  logic [gctr_width_lp-1:0]       global_ctr_i,
   input  logic [dirs_lp*ctr_width_p-1:0] idle_i,
   input  logic [dirs_lp*ctr_width_p-1:0] utilized_i,
   input  logic [dirs_lp*ctr_width_p-1:0] stalled_i,
   input  logic [dirs_lp*ctr_width_p-1:0] arbitrated_i,
   output logic                           v_o,
   output logic [rec_width_lp-1:0]        data_o,
   input  logic                           ready_i,
   output logic                           busy_o,
   output logic [drop_width_p-1:0]        drop_count_o
);

   router_stat_state_e state_q, state_d;
   logic [dir_width_lp-1:0]  dir_q, dir_d;
   logic [gctr_width_lp-1:0] gctr_q;
   logic [drop_width_p-1:0]  drop_q;
   logic                     load;
   logic                     drop;

   logic [4*dirs_lp*ctr_width_p-1:0]         delta_flat;
   logic [3:0][dirs_lp-1:0][ctr_width_p-1:0] delta;

   router_stat_snapshot #(
      .dirs_p      (dirs_lp),
      .ctr_width_p (ctr_width_p),
      .delta_p     (delta_p)
   ) u_snapshot (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .load_i       (load),
      .idle_i       (idle_i),
      .utilized_i   (utilized_i),
      .stalled_i    (stalled_i),
      .arbitrated_i (arbitrated_i),
      .delta_o      (delta_flat)
   );

   assign delta = delta_flat;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      load    = 1'b0;
      drop    = 1'b0;
      v_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (snap_v_i) begin
               load    = 1'b1;
               dir_d   = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            v_o  = 1'b1;
            // A strobe on the final handshake cycle is still dropped.
            drop = snap_v_i;
            if (ready_i) begin
               if (dir_q == dir_width_lp'(dirs_lp - 1)) begin
                  state_d = StIdle;
               end else begin
                  dir_d = dir_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= StIdle;
         dir_q   <= '0;
         gctr_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         if (load) begin
            gctr_q <= global_ctr_i;
         end
         if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
         end
      end
   end

   assign data_o = {gctr_q, dir_q, delta[0][dir_q], delta[1][dir_q], delta[2][dir_q],
                    delta[3][dir_q]};

   assign busy_o       = (state_q == StSend);
   assign drop_count_o = drop_q;

endmodule

// File: tb/tb_router_stat_serializer.sv
module tb_router_stat_serializer;

   localparam int DIRS = 5;
   localparam int CW   = 32;
   localparam int REC  = 32 + 3 + 4 * CW;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            snap;
   logic [31:0]     gctr;
   logic [DIRS*CW-1:0] idle_b, util_b, stall_b, arb_b;
   logic            ready;
   logic            v_o, v_s;
   logic [REC-1:0]  data_o, data_s;
   logic            busy_o, busy_s;
   logic [15:0]     drop_o;
   logic [1:0]      drop_s;

   logic [31:0] live [4][DIRS];

   // Reference model state
   logic [31:0]    m_cur  [4][DIRS];
   logic [31:0]    m_prev [4][DIRS];
   logic [REC-1:0] exp_q[$];
   int             pending;
   int             drops;
   logic [31:0]    seen_util [DIRS];

   int  n_cmp  = 0;
   int  n_fail = 0;
   bit  mon_en = 1'b0;
   bit  rand_ready = 1'b0;

   always #5 clk = ~clk;

   router_stat_serializer dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .snap_v_i     (snap),
      .global_ctr_i (gctr),
      .idle_i       (idle_b),
      .utilized_i   (util_b),
      .stalled_i    (stall_b),
      .arbitrated_i (arb_b),
      .v_o          (v_o),
      .data_o       (data_o),
      .ready_i      (ready),
      .busy_o       (busy_o),
      .drop_count_o (drop_o)
   );

   router_stat_serializer #(.drop_width_p(2)) dut_sat (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .snap_v_i     (snap),
      .global_ctr_i (gctr),
      .idle_i       (idle_b),
      .utilized_i   (util_b),
      .stalled_i    (stall_b),
      .arbitrated_i (arb_b),
      .v_o          (v_s),
      .data_o       (data_s),
      .ready_i      (ready),
      .busy_o       (busy_s),
      .drop_count_o (drop_s)
   );

   always_comb begin
      idle_b  = '0;
      util_b  = '0;
      stall_b = '0;
      arb_b   = '0;
      for (int d = 0; d < DIRS; d++) begin
         idle_b[d*CW +: CW]  = live[0][d];
         util_b[d*CW +: CW]  = live[1][d];
         stall_b[d*CW +: CW] = live[2][d];
         arb_b[d*CW +: CW]   = live[3][d];
      end
   end

   task automatic check(input string name, input logic ok, input logic [REC-1:0] act,
                        input logic [REC-1:0] exp);
      n_cmp++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap_pulse();
      snap = 1'b1;
      tick();
      snap = 1'b0;
   endtask

   task automatic randomize_live();
      for (int f = 0; f < 4; f++)
         for (int d = 0; d < DIRS; d++)
            live[f][d] = $urandom;
      gctr = $urandom;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (pending != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain", pending == 0, pending, 0);
   endtask

   // Ready driver: free-running random 30% or held high.
   initial forever begin
      @(posedge clk);
      #1;
      ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
   end

   // Behavioural model: a strobe is accepted only when no records of an earlier dump remain
   // (counting the one handshaking on this very edge); accepted dumps queue one record per dir.
   initial forever begin
      @(posedge clk);
      if (!reset_n) begin
         pending = 0;
         drops   = 0;
         exp_q.delete();
         for (int f = 0; f < 4; f++)
            for (int d = 0; d < DIRS; d++) begin
               m_cur[f][d]  = '0;
               m_prev[f][d] = '0;
            end
      end else begin
         bit hs;
         hs = (pending != 0) && ready;
         if (snap) begin
            if (pending == 0) begin
               for (int f = 0; f < 4; f++)
                  for (int d = 0; d < DIRS; d++) begin
                     m_prev[f][d] = m_cur[f][d];
                     m_cur[f][d]  = live[f][d];
                  end
               for (int d = 0; d < DIRS; d++)
                  exp_q.push_back({gctr, 3'(d), m_cur[0][d] - m_prev[0][d],
                                   m_cur[1][d] - m_prev[1][d], m_cur[2][d] - m_prev[2][d],
                                   m_cur[3][d] - m_prev[3][d]});
               pending = DIRS;
            end else if (drops != 65535) begin
               drops++;
            end
         end
         if (hs) pending--;
      end
   end

   // Monitor: checks the stream mid-cycle and pops on each handshake.
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         check("v_o", v_o == (exp_q.size() != 0), v_o, exp_q.size() != 0);
         check("busy_o", busy_o == (pending != 0), busy_o, pending != 0);
         check("busy_sat", busy_s == (pending != 0), busy_s, pending != 0);
         check("drop_count", drop_o == 16'(drops), drop_o, drops);
         check("drop_sat", drop_s == ((drops > 3) ? 2'd3 : 2'(drops)), drop_s,
               (drops > 3) ? 3 : drops);
         if (v_o && exp_q.size() != 0) begin
            check("data_o", data_o == exp_q[0], data_o, exp_q[0]);
            check("data_sat", data_s == exp_q[0], data_s, exp_q[0]);
            if (data_o[130:128] < DIRS) seen_util[data_o[130:128]] = data_o[95:64];
            if (ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      snap    = 1'b0;
      gctr    = '0;
      for (int f = 0; f < 4; f++)
         for (int d = 0; d < DIRS; d++)
            live[f][d] = '0;
      repeat (3) tick();
      mon_en = 1'b1;
      check("rst_v", v_o == 1'b0, v_o, 0);
      check("rst_busy", busy_o == 1'b0, busy_o, 0);
      check("rst_data", data_o == '0, data_o, 0);
      check("rst_drop", drop_o == '0, drop_o, 0);
      reset_n = 1'b1;
      tick();

      // Basic
      for (int d = 0; d < DIRS; d++) begin
         live[0][d] = 10;
         live[1][d] = 20;
         live[2][d] = 3;
         live[3][d] = 1;
      end
      gctr = 100;
      snap_pulse();
      wait_idle(50);
      check("basic_util", seen_util[4] == 32'd20, seen_util[4], 20);

      // Delta across counter wrap
      live[1][2] = 32'hFFFF_FFF0;
      gctr = 200;
      snap_pulse();
      wait_idle(50);
      live[1][2] = 32'h0000_0010;
      gctr = 300;
      snap_pulse();
      wait_idle(50);
      check("wrap_delta", seen_util[2] == 32'h20, seen_util[2], 32'h20);

      // Backpressure with random data
      rand_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         randomize_live();
         snap_pulse();
         wait_idle(400);
         repeat ($urandom_range(0, 3)) tick();
      end
      rand_ready = 1'b0;
      repeat (2) tick();

      // Overrun: strobes at t, t+2 and on the final handshake edge t+5
      randomize_live();
      snap_pulse();
      tick();
      randomize_live();
      snap_pulse();
      tick();
      tick();
      snap_pulse();
      wait_idle(50);
      check("overrun_drops", drop_o == 16'd2, drop_o, 2);
      randomize_live();
      snap_pulse();
      wait_idle(50);

      // Saturation: strobe held for six edges -> one accepted, five dropped
      randomize_live();
      snap = 1'b1;
      repeat (6) tick();
      snap = 1'b0;
      wait_idle(50);
      check("sat_drops16", drop_o == 16'd7, drop_o, 7);
      check("sat_drops2", drop_s == 2'd3, drop_s, 3);

      // Reset after two records
      randomize_live();
      snap_pulse();
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      check("midrst_v", v_o == 1'b0, v_o, 0);
      check("midrst_busy", busy_o == 1'b0, busy_o, 0);
      check("midrst_data", data_o == '0, data_o, 0);
      check("midrst_drop", drop_o == '0, drop_o, 0);
      reset_n = 1'b1;
      tick();
      randomize_live();
      snap_pulse();
      wait_idle(50);
      check("post_rst_abs", seen_util[2] == live[1][2], seen_util[2], live[1][2]);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
